// File: rtl/tt_sweep_ctrl.sv
// +--------------------------------------------------------------------------+
// | tt_sweep_ctrl: exhaustive input sweep comparing a DUT function to a ref.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tt_sweep_ctrl #(
  parameter int NIN = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [3:0]     settle_cfg,
  output logic [NIN-1:0] x_out,
  input  logic           y_dut,
  input  logic           y_ref,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [NIN:0]   onset_cnt,
  output logic [NIN:0]   mism_cnt,
  output logic [NIN-1:0] first_mism,
  output logic           first_mism_vld
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t         state_q;
  logic [NIN-1:0] x_q;
  logic [3:0]     cfg_q;
  logic [3:0]     cnt_q;
  logic           busy_q;
  logic           done_q;
  logic           pass_q;
  logic [NIN:0]   onset_q;
  logic [NIN:0]   mism_q;
  logic [NIN-1:0] fm_q;
  logic           fm_vld_q;

  logic w_last;
  logic w_mism;

  assign w_last = &x_q;
  assign w_mism = y_dut ^ y_ref;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      cfg_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      onset_q  <= '0;
      mism_q   <= '0;
      fm_q     <= '0;
      fm_vld_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // start together with abort is treated as no request at all
          if (start && !abort) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            x_q      <= '0;
            cfg_q    <= settle_cfg;
            cnt_q    <= settle_cfg;
            pass_q   <= 1'b0;
            onset_q  <= '0;
            mism_q   <= '0;
            fm_q     <= '0;
            fm_vld_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            onset_q <= onset_q + {{NIN{1'b0}}, y_dut};
            mism_q  <= mism_q + {{NIN{1'b0}}, w_mism};
            if (w_mism && !fm_vld_q) begin
              fm_q     <= x_q;
              fm_vld_q <= 1'b1;
            end
            // the final vector holds so x_out never wraps back to zero
            if (w_last) begin
              state_q <= S_FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              x_q   <= x_q + 1'b1;
              cnt_q <= cfg_q;
            end
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          pass_q  <= (mism_q == '0);
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign x_out          = x_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign onset_cnt      = onset_q;
  assign mism_cnt       = mism_q;
  assign first_mism     = fm_q;
  assign first_mism_vld = fm_vld_q;

endmodule

`default_nettype wire

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, both named as below.
REQ-002 Parameter NIN, default 8, SHALL set the number of primary inputs swept (legal 2..12).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  single-cycle request to begin a sweep, honoured only in IDLE.
REQ-006 abort  input  1  terminates a running sweep.
REQ-007 settle_cfg  input  4  extra wait cycles per vector before sampling, latched at start.
REQ-008 x_out  output  NIN  input vector driven to both the function under test and the golden function.
REQ-009 y_dut  input  1  output of the optimized function.
REQ-010 y_ref  input  1  output of the golden function.
REQ-011 busy  output  1  high while a sweep is in RUN.
REQ-012 done  output  1  one-cycle pulse when a sweep completes normally.
REQ-013 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-014 onset_cnt  output  NIN+1  count of vectors with y_dut=1.
REQ-015 mism_cnt  output  NIN+1  count of vectors with y_dut!=y_ref.
REQ-016 first_mism  output  NIN  vector of the first mismatch.
REQ-017 first_mism_vld  output  1  first_mism holds a valid value.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and FINISH.
REQ-019 IDLE with start=1 and abort=0: next state RUN, x_out<=0, settle counter<=latched settle_cfg, onset_cnt/mism_cnt/first_mism/first_mism_vld/pass cleared.
REQ-020 IDLE with start=1 and abort=1: the block SHALL stay in IDLE with no register change.
REQ-021 In RUN with settle counter nonzero, the counter SHALL decrement and nothing is sampled.
REQ-022 In RUN with settle counter zero, y_dut/y_ref SHALL be sampled at that edge: onset_cnt+=y_dut, mism_cnt+=(y_dut^y_ref), and on the first mismatch first_mism<=x_out and first_mism_vld<=1.
REQ-023 After a sample with x_out not all-ones, x_out SHALL increment by 1 and the counter SHALL reload settle_cfg.
REQ-024 After a sample with x_out all-ones, next state SHALL be FINISH and x_out SHALL hold (no wrap to 0).
REQ-025 Each vector SHALL occupy exactly settle_cfg+1 RUN cycles; a full sweep SHALL take 2^NIN*(settle_cfg+1) RUN cycles.
REQ-026 FINISH SHALL last one cycle with done=1 and pass<=(mism_cnt==0), then return to IDLE.
REQ-027 busy SHALL equal (state==RUN).
REQ-028 start SHALL be ignored in RUN and FINISH.
REQ-029 abort in RUN SHALL force IDLE next cycle with no sample taken that edge, no done pulse, pass=0, and counters holding their partial values.
REQ-030 abort in FINISH SHALL be ignored; done still pulses.
REQ-031 Counters SHALL be NIN+1 bits wide so 2^NIN is representable without overflow.
REQ-032 Results SHALL hold stable in IDLE until the next accepted start.
REQ-033 x_out SHALL be a registered output, changing only on clock edges.

Reset
REQ-034 When rst_n=0 at a clock edge, the block SHALL go to IDLE with x_out=0, busy=0, done=0, pass=0, onset_cnt=0, mism_cnt=0, first_mism=0, first_mism_vld=0 and settle counter=0, overriding start and abort.
REQ-035 Reset asserted mid-sweep SHALL discard all partial results; no done pulse SHALL follow.

Verification
REQ-036 NIN=8, settle_cfg=0, y_dut=y_ref=x_out[0], start -> done pulses in the 257th cycle after start; onset_cnt=128, mism_cnt=0, pass=1, first_mism_vld=0.
REQ-037 settle_cfg=3, y_dut=y_ref=1 -> busy high for 1024 cycles; onset_cnt=256 (bit 8 set); pass=1.
REQ-038 y_ref=y_dut except inverted at x_out=0x05 and 0xA0 -> mism_cnt=2, first_mism=0x05, first_mism_vld=1, pass=0.
REQ-039 abort asserted while x_out=0x40 -> IDLE next cycle, no done pulse, onset_cnt frozen, pass=0; a following start restarts from x_out=0 with cleared counters.
REQ-040 rst_n low for one cycle at x_out=0x80 -> all outputs at reset values next cycle; start and start+abort in the same cycle while busy -> ignored.
